ex_muldiv: RTL

- Multi-cycle RV32M execution unit in the EX stage, next to the ALU.
- Consumes the instruction held in the ID/EX pipeline register: funct3 plus forwarded rs1/rs2 values.
- Computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU iteratively.
- While busy, asserts a stall to the hazard unit, which holds PC, IF/ID and ID/EX. Result is muxed into the EX result path on the done cycle.

---
 rtl/riscv_m_pkg.sv | 24 ++
 rtl/muldiv_step.sv | 33 +++
 rtl/ex_muldiv.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/riscv_m_pkg.sv
// Shared encodings for the RV32M execution unit: funct3 op codes,
// the funct7 marker for M-extension R-type ops, and the FSM state type.
package riscv_m_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath. The 2*XLEN accumulator holds
// {partial product, remaining multiplier bits} for multiply and
// {partial remainder, remaining dividend / quotient bits} for divide.
module muldiv_step
  import riscv_m_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic              is_div,
  input  logic [XLEN-1:0]   operand,
  input  logic [2*XLEN-1:0] acc_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0] mul_sum;
  logic [XLEN:0] div_shift;
  logic [XLEN:0] div_diff;

  // Shift-add for multiply, trial-subtract (restoring) for divide
  always_comb begin
    mul_sum   = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, operand} : '0);
    div_shift = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
    div_diff  = div_shift - {1'b0, operand};
    if (!is_div) begin
      acc_o = {mul_sum, acc_i[XLEN-1:1]};
    end else if (!div_diff[XLEN]) begin
      acc_o = {div_diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
    end else begin
      acc_o = {div_shift[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage. Stalls the
// pipeline while working and pulses done for one cycle with the result.
module ex_muldiv
  import riscv_m_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int N  = XLEN / UNROLL;
  localparam int CW = $clog2(N) + 1;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic [2:0]          f3_q;
  logic [XLEN-1:0]     op_q;
  logic [2*XLEN-1:0]   acc_q;
  logic                neg_res_q, neg_rem_q;
  logic [XLEN-1:0]     result_q;

  // Operand sign analysis on the live inputs (used only when accepting)
  logic            is_div_in, a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            fast, accept, last_iter;
  logic [XLEN-1:0] fast_res;

  always_comb begin
    is_div_in = funct3[2];
    a_signed  = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                (funct3 == F3_DIV)  || (funct3 == F3_REM);
    b_signed  = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    a_neg     = a_signed & rs1_val[XLEN-1];
    b_neg     = b_signed & rs2_val[XLEN-1];
    abs_a     = a_neg ? -rs1_val : rs1_val;
    abs_b     = b_neg ? -rs2_val : rs2_val;
    accept    = (state_q == IDLE) && start && !kill;
    last_iter = (cnt_q == CW'(N - 1));
    fast      = 1'b0;
    fast_res  = '0;
    // Divide-by-zero and signed overflow bypass the iteration entirely
    if (is_div_in && (rs2_val == '0)) begin
      fast     = 1'b1;
      fast_res = funct3[1] ? rs1_val : '1;
    end else if ((funct3 == F3_DIV || funct3 == F3_REM) &&
                 (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val == '1)) begin
      fast     = 1'b1;
      fast_res = funct3[1] ? '0 : rs1_val;
    end
  end

  // Chain of UNROLL single-bit steps per cycle
  logic [2*XLEN-1:0] chain [UNROLL+1];
  assign chain[0] = acc_q;

  generate
    for (genvar gi = 0; gi < UNROLL; gi++) begin : g_step
      muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div  (f3_q[2]),
        .operand (op_q),
        .acc_i   (chain[gi]),
        .acc_o   (chain[gi+1])
      );
    end
  endgenerate

  // Sign fix-up and result selection from the final accumulator value
  logic [2*XLEN-1:0] acc_step, prod;
  logic [XLEN-1:0]   quo, rem, calc_res;

  always_comb begin
    acc_step = chain[UNROLL];
    prod     = neg_res_q ? -acc_step : acc_step;
    quo      = neg_res_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem      = neg_rem_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    case (f3_q)
      F3_MUL:                    calc_res = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: calc_res = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:           calc_res = quo;
      default:                   calc_res = rem;
    endcase
  end

  // Next-state and stall request
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    case (state_q)
      IDLE: begin
        busy = start && !kill;
        if (accept) state_d = fast ? DONE : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (kill)           state_d = IDLE;
        else if (last_iter) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand latches, iteration and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      f3_q      <= '0;
      op_q      <= '0;
      acc_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (accept) begin
            f3_q      <= funct3;
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            op_q      <= is_div_in ? abs_b : abs_a;
            acc_q     <= {{XLEN{1'b0}}, (is_div_in ? abs_a : abs_b)};
            if (fast) result_q <= fast_res;
          end
        end
        CALC: begin
          if (!kill) begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + 1'b1;
            if (last_iter) result_q <= calc_res;
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule
